// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable synchronous down-counter with one-cycle terminal-count pulse and optional auto-reload
module sync_down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_en,
   input  logic             i_auto_reload,
   output logic [WIDTH-1:0] o_q,
   output logic             o_busy,
   output logic             o_tc
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t           r_state, w_next_state;
   logic [WIDTH-1:0] r_q, r_rld, w_next_q, w_next_rld;
   logic             r_tc, w_next_tc;
   logic             w_terminal;
   assign w_terminal = (r_state == RUN) && i_en && (r_q == WIDTH'(1));
   // next state: load beats counting; terminal is q==1 so the decrement never wraps
   always_comb begin
      w_next_state = r_state;
      w_next_q     = r_q;
      w_next_rld   = r_rld;
      w_next_tc    = 1'b0;
      if (i_load) begin
         w_next_q     = i_din;
         w_next_rld   = i_din;
         w_next_state = (i_din != '0) ? RUN : IDLE;
      end else if (w_terminal) begin
         w_next_tc    = 1'b1;
         w_next_q     = i_auto_reload ? r_rld : '0;
         w_next_state = i_auto_reload ? RUN : IDLE;
      end else if (r_state == RUN && i_en) begin
         w_next_q = r_q - WIDTH'(1);
      end
   end
   // state registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= IDLE;
         r_q     <= '0;
         r_rld   <= '0;
         r_tc    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_q     <= w_next_q;
         r_rld   <= w_next_rld;
         r_tc    <= w_next_tc;
      end
   end
   assign o_q    = r_q;
   assign o_busy = (r_state == RUN);
   assign o_tc   = r_tc;
endmodule

// File: tb/tb_sync_down_timer.sv
// tb_sync_down_timer: table-driven directed checks of sync_down_timer plus hand-written corner sequences
module tb_sync_down_timer;
   typedef struct {
      logic       rst;
      logic       load;
      logic [3:0] din;
      logic       en;
      logic       ar;
      logic [3:0] q;
      logic       busy;
      logic       tc;
   } vec_t;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [3:0] din = '0;
   logic       en = 1'b0;
   logic       ar = 1'b0;
   logic [3:0] q;
   logic       busy;
   logic       tc;
   int         errors = 0;
   int         checks = 0;
   vec_t       vecs[$];
   sync_down_timer #(.WIDTH(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_load(load), .i_din(din), .i_en(en),
      .i_auto_reload(ar), .o_q(q), .o_busy(busy), .o_tc(tc)
   );
   always #5 clk = ~clk;
   task automatic add(input logic r, input logic l, input logic [3:0] d, input logic e, input logic a,
                      input logic [3:0] eq, input logic eb, input logic et);
      vec_t v;
      v.rst = r; v.load = l; v.din = d; v.en = e; v.ar = a; v.q = eq; v.busy = eb; v.tc = et;
      vecs.push_back(v);
   endtask
   task automatic step(input logic r, input logic l, input logic [3:0] d, input logic e, input logic a);
      rst = r; load = l; din = d; en = e; ar = a;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input logic [3:0] eq, input logic eb, input logic et);
      checks += 3;
      if (q !== eq) begin errors++; $display("FAIL %s: q=%0d expected %0d", name, q, eq); end
      if (busy !== eb) begin errors++; $display("FAIL %s: busy=%0b expected %0b", name, busy, eb); end
      if (tc !== et) begin errors++; $display("FAIL %s: tc=%0b expected %0b", name, tc, et); end
   endtask
   initial begin
      // reset then idle with en toggling
      add(0,0,0,0,0, 0,0,0); add(0,0,0,1,0, 0,0,0);
      add(1,0,0,1,0, 0,0,0); add(1,0,0,0,0, 0,0,0); add(1,0,0,1,1, 0,0,0);
      // one-shot from 5
      add(1,1,5,1,0, 5,1,0); add(1,0,0,1,0, 4,1,0); add(1,0,0,1,0, 3,1,0);
      add(1,0,0,1,0, 2,1,0); add(1,0,0,1,0, 1,1,0); add(1,0,0,1,0, 0,0,1);
      add(1,0,0,1,0, 0,0,0);
      // gated count from 3, en 1,0,0,1,1
      add(1,1,3,1,0, 3,1,0); add(1,0,0,1,0, 2,1,0); add(1,0,0,0,0, 2,1,0);
      add(1,0,0,0,0, 2,1,0); add(1,0,0,1,0, 1,1,0); add(1,0,0,1,0, 0,0,1);
      // auto-reload from 4 for 12 edges, then drop auto_reload
      add(1,1,4,1,1, 4,1,0);
      for (int p = 0; p < 3; p++) begin
         add(1,0,0,1,1, 3,1,0); add(1,0,0,1,1, 2,1,0); add(1,0,0,1,1, 1,1,0); add(1,0,0,1,1, 4,1,1);
      end
      add(1,0,0,1,0, 3,1,0); add(1,0,0,1,0, 2,1,0); add(1,0,0,1,0, 1,1,0);
      add(1,0,0,1,0, 0,0,1); add(1,0,0,1,1, 0,0,0);
      // load collides with terminal
      add(1,1,7,1,0, 7,1,0);
      for (int k = 6; k >= 1; k--) add(1,0,0,1,0, 4'(k),1,0);
      add(1,1,2,1,0, 2,1,0); add(1,0,0,1,0, 1,1,0); add(1,0,0,1,0, 0,0,1);
      // mid-run reset, reset beats load, zero load
      add(1,1,9,1,0, 9,1,0); add(1,0,0,1,0, 8,1,0); add(1,0,0,1,0, 7,1,0);
      add(1,0,0,1,0, 6,1,0); add(0,0,0,1,0, 0,0,0); add(0,1,5,1,0, 0,0,0);
      add(1,1,0,1,0, 0,0,0); add(1,0,0,1,1, 0,0,0);
      @(negedge clk);
      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].en, vecs[i].ar);
         check($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].tc);
      end
      // din==1 one-shot: tc one enabled edge after load
      step(1,1,1,1,0); check("din1_load", 1,1,0);
      step(1,0,0,1,0); check("din1_tc", 0,0,1);
      step(1,0,0,1,0); check("din1_after", 0,0,0);
      // load while busy aborts period with no tc
      step(1,1,3,1,0); check("abort_load", 3,1,0);
      step(1,0,0,1,0); check("abort_cnt", 2,1,0);
      step(1,1,6,0,0); check("abort_reload", 6,1,0);
      step(1,0,0,1,0); check("abort_cnt2", 5,1,0);
      // back-to-back tc with rld==1 and auto_reload
      step(1,1,1,1,1); check("b2b_load", 1,1,0);
      for (int k = 0; k < 3; k++) begin
         step(1,0,0,1,1); check($sformatf("b2b_tc%0d", k), 1,1,1);
      end
      step(1,0,0,0,1); check("b2b_hold", 1,1,0);
      step(1,0,0,1,0); check("b2b_stop", 0,0,1);
      step(1,0,0,1,0); check("b2b_idle", 0,0,0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sync_down_timer.md
# sync_down_timer

Synchronous, loadable down-counter with terminal-count flag and optional auto-reload. All flops share one clock, unlike a ripple counter. It counts a loaded value down to terminal and emits a one-cycle `tc` pulse. It is the timing/countdown companion to the team's up-counter blocks: it produces event ticks and timeouts from a programmed period instead of accumulating counts.

## Interface
- `WIDTH`, default 4: counter and load-value width in bits; must be ≥ 2.
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: synchronous, active-low reset; sampled on the `clk` rising edge; clears all state.
- `load`  input  1: load strobe; captures `din` into the counter and the reload register.
- `din`  input  WIDTH: load value, i.e. the period in enabled cycles.
- `en`  input  1: count enable; decrement only when high and busy.
- `auto_reload`  input  1: when high at terminal, restart from the reload register instead of stopping.
- `q`  output  WIDTH: current count (registered).
- `busy`  output  1: high while in RUN (registered).
- `tc`  output  1: terminal-count pulse, high for exactly one cycle (registered).

## Operation
- Internal state: count register `q`, reload register `rld` (WIDTH bits), FSM {IDLE, RUN}.
- Reset (`rst==0` at an edge): `q=0`, `rld=0`, state IDLE, `busy=0`, `tc=0`. Reset overrides every other input.
- Priority at each edge: reset > `load` > count.
- `load==1`, any state:
  - `q<=din`, `rld<=din`, `tc<=0`.
  - If `din!=0`, go to RUN. If `din==0`, go to IDLE.
- RUN, `en==0`: hold `q`, `tc<=0`.
- RUN, `en==1`, `q>1`: `q<=q-1`, `tc<=0`.
- RUN, `en==1`, `q==1` (terminal): `tc<=1`.
  - If `auto_reload==1`: `q<=rld`, stay in RUN.
  - Else: `q<=0`, go to IDLE.
- IDLE: `q` holds, `en` and `auto_reload` are ignored, `tc<=0`.
- `busy` equals (state==RUN), registered with the state.
- Arithmetic: decrement is modulo 2^WIDTH but never wraps in practice, because terminal is detected at `q==1`.
- `auto_reload` is sampled only at the terminal edge. Changing it mid-run only affects the next terminal event.
- With `auto_reload` set, the period is `rld` enabled cycles per `tc`. `q` cycles N, N-1, …, 1, N, … and never shows 0.

## Timing
- Load at edge k:
  - `q==din` and `busy==1` are visible after edge k.
  - With `en` held high, `tc==1` during the cycle after edge k+N (N=`din`), and low again after edge k+N+1.
  - Without reload, `q==0` and `busy==0` after edge k+N.
- Every `en==0` cycle in RUN delays `tc` by one cycle.
- `load` on the same edge as terminal: the load wins, `tc` stays 0, and the count restarts from the new `din`.
- `load` while `busy`: restarts immediately; no `tc` is issued for the aborted period.
- `din==1`: `tc` follows one enabled edge after the load.
- Reset mid-run: all outputs are 0 after that edge, and no `tc` is issued.
- Back-to-back `tc` with `auto_reload` and `rld==1`: `tc` stays high continuously, one pulse per cycle.

## Test plan
- Reset then idle: hold `rst=0` for 2 edges, release, toggle `en` → `q=0`, `busy=0`, `tc=0` throughout.
- One-shot: load `din=5`, `en=1` → `q`=5,4,3,2,1,0 on successive edges; `tc` high exactly one cycle with `q==0`; `busy` falls with it.
- Gated count: load 3, `en` pattern 1,0,0,1,1 → `q`=3,2,2,2,1,0; `tc` coincides with `q` reaching 0.
- Auto-reload: load 4, `auto_reload=1`, `en=1` for 12 edges → `q`=4,3,2,1,4,3,2,1,…; `tc` high every 4th cycle, 3 pulses; `busy` stays 1.
- Load collisions: load 7, count to `q==1`, assert `load` with `din=2` at the terminal edge → no `tc`, `q=2`, then `tc` two edges later.
- Mid-run reset and zero load: load 9, reset after 3 edges → all outputs 0; then load `din=0` → `busy=0`, `tc=0`, `q=0`.
